// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the MII transmit nibbler.
// The FCS helper keeps the on-wire bit order in one place.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IPG
    } tx_state_t;

    localparam int          PREAMBLE_NIBBLES = 15;
    localparam logic [3:0]  SFD_NIBBLE       = 4'hD;
    localparam logic [3:0]  PREAMBLE_NIBBLE  = 4'h5;

    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    // MTxD[0] goes on the wire first, so it carries the complemented CRC MSB.
    function automatic logic [3:0] fcs_nibble(input logic [31:0] crc);
        return ~{crc[28], crc[29], crc[30], crc[31]};
    endfunction

endpackage

// File: rtl/eth_tx_crc32.sv
// Combinational CRC-32 update for one MII nibble.
// data[0] is the first bit on the wire; the register is kept MSB-first.
module eth_tx_crc32
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [3:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/eth_tx_nibbler.sv
// MII transmit nibbler: preamble/SFD, byte serialisation, padding, FCS and
// inter-packet gap, with TxUsedData/TxDone/TxAbort handshakes to upstream.
module eth_tx_nibbler
    import eth_tx_pkg::*;
#(
    parameter int MIN_FL      = 64,
    parameter int IPG_NIBBLES = 24
) (
    input  logic       MTxClk,
    input  logic       TxReset,
    input  logic       TxStartFrm,
    input  logic       TxEndFrm,
    input  logic [7:0] TxData,
    input  logic       PadIn,
    input  logic       CrcEn,
    input  logic       TxAbortRq,
    output logic [3:0] MTxD,
    output logic       MTxEn,
    output logic       TxUsedData,
    output logic       TxDone,
    output logic       TxAbort
);

    localparam logic [15:0]      PAD_BYTES = 16'(MIN_FL - 4);
    localparam int               IPG_W     = $clog2(IPG_NIBBLES + 1);
    // The IDLE cycle that samples TxStartFrm is the last nibble of the gap.
    localparam logic [IPG_W-1:0] IPG_LAST  = IPG_W'(IPG_NIBBLES - 2);

    tx_state_t        state;
    logic [3:0]       nib_cnt;
    logic [7:0]       hold_byte;
    logic             hold_last;
    logic             high_half;
    logic             pad_en;
    logic             crc_en;
    logic [15:0]      byte_cnt;
    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [IPG_W-1:0] ipg_cnt;

    logic [15:0]      byte_cnt_inc;
    logic             more_pad;
    logic             more_pad_inc;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    eth_tx_crc32 u_crc (
        .crc      (crc),
        .data     (MTxD),
        .crc_next (crc_next)
    );

    assign byte_cnt_inc = sat_inc16(byte_cnt);
    assign more_pad     = pad_en && (byte_cnt < PAD_BYTES);
    assign more_pad_inc = pad_en && (byte_cnt_inc < PAD_BYTES);

    always_ff @(posedge MTxClk or posedge TxReset) begin
        if (TxReset) begin
            state      <= ST_IDLE;
            MTxD       <= 4'h0;
            MTxEn      <= 1'b0;
            TxUsedData <= 1'b0;
            TxDone     <= 1'b0;
            TxAbort    <= 1'b0;
            nib_cnt    <= 4'd0;
            hold_byte  <= 8'h00;
            hold_last  <= 1'b0;
            high_half  <= 1'b0;
            pad_en     <= 1'b0;
            crc_en     <= 1'b0;
            byte_cnt   <= 16'd0;
            crc        <= CRC_INIT;
            ipg_cnt    <= '0;
        end else begin
            TxUsedData <= 1'b0;
            TxDone     <= 1'b0;
            TxAbort    <= 1'b0;

            // A request arriving on the final nibble loses to the completed frame.
            if (TxAbortRq && !TxDone &&
                (state inside {ST_PREAMBLE, ST_DATA, ST_PAD, ST_FCS})) begin
                state   <= ST_IPG;
                MTxEn   <= 1'b0;
                MTxD    <= 4'h0;
                TxAbort <= 1'b1;
                ipg_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (TxStartFrm && !TxAbortRq) begin
                            state    <= ST_PREAMBLE;
                            MTxEn    <= 1'b1;
                            MTxD     <= PREAMBLE_NIBBLE;
                            nib_cnt  <= 4'd0;
                            pad_en   <= PadIn;
                            crc_en   <= CrcEn;
                            byte_cnt <= 16'd0;
                            crc      <= CRC_INIT;
                        end
                    end

                    ST_PREAMBLE: begin
                        if (nib_cnt == 4'(PREAMBLE_NIBBLES)) begin
                            state     <= ST_DATA;
                            hold_byte <= TxData;
                            hold_last <= TxEndFrm;
                            MTxD      <= TxData[3:0];
                            high_half <= 1'b0;
                        end else begin
                            nib_cnt <= nib_cnt + 4'd1;
                            if (nib_cnt == 4'(PREAMBLE_NIBBLES - 1)) begin
                                MTxD       <= SFD_NIBBLE;
                                TxUsedData <= 1'b1;
                            end else begin
                                MTxD <= PREAMBLE_NIBBLE;
                            end
                        end
                    end

                    // Pad bytes reuse the data path with a constant zero byte.
                    ST_DATA, ST_PAD: begin
                        crc <= crc_next;
                        if (!high_half) begin
                            high_half <= 1'b1;
                            byte_cnt  <= byte_cnt_inc;
                            MTxD      <= (state == ST_PAD) ? 4'h0 : hold_byte[7:4];
                            if (state == ST_DATA && !hold_last) begin
                                TxUsedData <= 1'b1;
                            end else if (!more_pad_inc && !crc_en) begin
                                TxDone <= 1'b1;
                            end
                        end else begin
                            high_half <= 1'b0;
                            if (state == ST_DATA && !hold_last) begin
                                hold_byte <= TxData;
                                hold_last <= TxEndFrm;
                                MTxD      <= TxData[3:0];
                            end else if (more_pad) begin
                                state <= ST_PAD;
                                MTxD  <= 4'h0;
                            end else if (crc_en) begin
                                state   <= ST_FCS;
                                MTxD    <= fcs_nibble(crc_next);
                                crc     <= {crc_next[27:0], 4'h0};
                                nib_cnt <= 4'd0;
                            end else begin
                                state   <= ST_IPG;
                                MTxEn   <= 1'b0;
                                MTxD    <= 4'h0;
                                ipg_cnt <= '0;
                            end
                        end
                    end

                    ST_FCS: begin
                        if (nib_cnt == 4'd7) begin
                            state   <= ST_IPG;
                            MTxEn   <= 1'b0;
                            MTxD    <= 4'h0;
                            ipg_cnt <= '0;
                        end else begin
                            MTxD    <= fcs_nibble(crc);
                            crc     <= {crc[27:0], 4'h0};
                            nib_cnt <= nib_cnt + 4'd1;
                            if (nib_cnt == 4'd6) begin
                                TxDone <= 1'b1;
                            end
                        end
                    end

                    ST_IPG: begin
                        if (ipg_cnt == IPG_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            ipg_cnt <= ipg_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        MTxEn <= 1'b0;
                        MTxD  <= 4'h0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_nibbler.sv
// Directed bench for eth_tx_nibbler: the bench plays the upstream byte source
// and scores every transmitted nibble against a reflected CRC-32 reference.
`timescale 1ns/1ps
module tb_eth_tx_nibbler;

    localparam int MIN_FL      = 64;
    localparam int IPG_NIBBLES = 24;

    logic       MTxClk = 1'b0;
    logic       TxReset;
    logic       TxStartFrm;
    logic       TxEndFrm;
    logic [7:0] TxData;
    logic       PadIn;
    logic       CrcEn;
    logic       TxAbortRq;
    logic [3:0] MTxD;
    logic       MTxEn;
    logic       TxUsedData;
    logic       TxDone;
    logic       TxAbort;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] data_q[$];
    logic [7:0] frame_q[$];
    logic [3:0] exp_q[$];

    int en_cnt, used_cnt, done_cnt, abort_cnt;
    int first_en_cyc, done_cyc, abort_cyc, abort_req_cyc, last_used_cyc;

    eth_tx_nibbler #(
        .MIN_FL      (MIN_FL),
        .IPG_NIBBLES (IPG_NIBBLES)
    ) dut (
        .MTxClk     (MTxClk),
        .TxReset    (TxReset),
        .TxStartFrm (TxStartFrm),
        .TxEndFrm   (TxEndFrm),
        .TxData     (TxData),
        .PadIn      (PadIn),
        .CrcEn      (CrcEn),
        .TxAbortRq  (TxAbortRq),
        .MTxD       (MTxD),
        .MTxEn      (MTxEn),
        .TxUsedData (TxUsedData),
        .TxDone     (TxDone),
        .TxAbort    (TxAbort)
    );

    always #5 MTxClk = ~MTxClk;

    always @(posedge MTxClk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reflected (LSB-first) CRC-32 over the padded frame, returned as the FCS value.
    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (frame_q[i]) begin
            c = c ^ {24'h0, frame_q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build_expected(input bit pad, input bit crc);
        logic [31:0] fcs;
        exp_q.delete();
        frame_q = data_q;
        if (pad) begin
            while (frame_q.size() < MIN_FL - 4) frame_q.push_back(8'h00);
        end
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        foreach (frame_q[i]) begin
            exp_q.push_back(frame_q[i][3:0]);
            exp_q.push_back(frame_q[i][7:4]);
        end
        if (crc) begin
            fcs = ref_fcs();
            for (int k = 0; k < 8; k++) exp_q.push_back(fcs[4*k +: 4]);
        end
    endtask

    // Drives one frame from data_q and scores the wire until TxDone, TxAbort,
    // or the stop_at-th transmitted nibble (for the mid-frame reset step).
    task automatic run_frame(input bit pad, input bit crc, input int abort_at, input int stop_at);
        int         idx;
        int         nib;
        bit         adv;
        bit         fin;
        logic [3:0] e;
        idx = 0;
        nib = 0;
        fin = 1'b0;
        build_expected(pad, crc);
        en_cnt = 0; used_cnt = 0; done_cnt = 0; abort_cnt = 0;
        first_en_cyc = -1; done_cyc = -1; abort_cyc = -1; abort_req_cyc = -1; last_used_cyc = -1;
        PadIn      = pad;
        CrcEn      = crc;
        TxAbortRq  = 1'b0;
        TxData     = data_q[0];
        TxEndFrm   = (data_q.size() == 1);
        TxStartFrm = 1'b1;
        for (int t = 0; t < 2000 && !fin; t++) begin
            @(negedge MTxClk);
            TxAbortRq = 1'b0;
            if (MTxEn) begin
                en_cnt++;
                nib++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("nibble_overrun", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("nibble", 32'(MTxD), 32'(e));
                end
            end
            if (TxUsedData) begin
                used_cnt++;
                if (last_used_cyc >= 0) check("used_spacing", cyc - last_used_cyc, 32'd2);
                last_used_cyc = cyc;
            end
            if (TxDone) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_on_last_nibble", 32'(exp_q.size()), 32'd0);
                fin = 1'b1;
            end
            if (TxAbort) begin
                abort_cnt++;
                abort_cyc = cyc;
                check("abort_drops_en", 32'(MTxEn), 32'd0);
                fin = 1'b1;
            end
            if (nib == stop_at) fin = 1'b1;
            if (!fin) begin
                if (abort_at >= 0 && nib == abort_at && MTxEn) begin
                    TxAbortRq     = 1'b1;
                    abort_req_cyc = cyc;
                end
                adv = TxUsedData;
                @(posedge MTxClk);
                #1;
                if (adv) begin
                    TxStartFrm = 1'b0;
                    idx++;
                    if (idx < data_q.size()) begin
                        TxData   = data_q[idx];
                        TxEndFrm = (idx == data_q.size() - 1);
                    end else begin
                        TxEndFrm = 1'b0;
                    end
                end
            end
        end
        if (!fin) check("frame_timeout", 32'(fin), 32'd1);
    endtask

    initial begin
        int gap_low;
        int saved;

        TxReset    = 1'b1;
        TxStartFrm = 1'b0;
        TxEndFrm   = 1'b0;
        TxData     = 8'h00;
        PadIn      = 1'b0;
        CrcEn      = 1'b0;
        TxAbortRq  = 1'b0;
        repeat (3) @(negedge MTxClk);
        check("reset_mtxen", 32'(MTxEn), 32'd0);
        check("reset_mtxd", 32'(MTxD), 32'd0);
        check("reset_used", 32'(TxUsedData), 32'd0);
        check("reset_done", 32'(TxDone), 32'd0);
        check("reset_abort", 32'(TxAbort), 32'd0);
        TxReset = 1'b0;

        // Abort request while idle is ignored.
        TxAbortRq = 1'b1;
        repeat (4) @(negedge MTxClk);
        check("idle_abort_en", 32'(MTxEn), 32'd0);
        check("idle_abort_pulse", 32'(TxAbort), 32'd0);
        TxAbortRq = 1'b0;
        @(negedge MTxClk);

        // One-byte raw frame, then the gap.
        data_q = '{8'hA5};
        run_frame(1'b0, 1'b0, -1, -1);
        check("f1_en_cycles", en_cnt, 32'd18);
        check("f1_done_count", done_cnt, 32'd1);
        gap_low = 0;
        for (int i = 0; i < IPG_NIBBLES; i++) begin
            @(negedge MTxClk);
            if (!MTxEn) gap_low++;
        end
        check("f1_gap_low", gap_low, IPG_NIBBLES);

        // "123456789" with FCS 0xCBF43926.
        data_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(1'b0, 1'b1, -1, -1);
        check("crc_used_count", used_cnt, 32'd9);
        check("crc_en_cycles", en_cnt, 32'd42);
        check("crc_done_count", done_cnt, 32'd1);
        repeat (IPG_NIBBLES) @(negedge MTxClk);

        // 10-byte frame padded to 60 bytes plus FCS.
        data_q.delete();
        for (int i = 0; i < 10; i++) data_q.push_back(8'(8'h10 + i * 7));
        run_frame(1'b1, 1'b1, -1, -1);
        check("pad_en_cycles", en_cnt, 32'd144);
        check("pad_done_count", done_cnt, 32'd1);
        check("pad_used_count", used_cnt, 32'd10);
        repeat (IPG_NIBBLES) @(negedge MTxClk);

        // Abort during the low nibble of the 5th byte.
        data_q.delete();
        for (int i = 0; i < 8; i++) data_q.push_back(8'(8'hC3 ^ (i * 17)));
        run_frame(1'b0, 1'b1, 25, -1);
        check("abort_count", abort_cnt, 32'd1);
        check("abort_no_done", done_cnt, 32'd0);
        check("abort_latency", abort_cyc - abort_req_cyc, 32'd1);
        saved = abort_cyc;
        data_q = '{8'h5A, 8'h00, 8'hFF};
        run_frame(1'b0, 1'b1, -1, -1);
        check("abort_restart_gap", first_en_cyc - saved, IPG_NIBBLES);
        check("abort_restart_done", done_cnt, 32'd1);
        repeat (IPG_NIBBLES) @(negedge MTxClk);

        // Back-to-back: next request held high through the gap.
        data_q = '{8'h01, 8'h23, 8'h45, 8'h67};
        run_frame(1'b0, 1'b1, -1, -1);
        saved = done_cyc;
        data_q = '{8'h89, 8'hAB};
        run_frame(1'b0, 1'b0, -1, -1);
        check("b2b_start_gap", first_en_cyc - saved, IPG_NIBBLES + 1);
        check("b2b_done_count", done_cnt, 32'd1);
        repeat (IPG_NIBBLES) @(negedge MTxClk);

        // Reset in the middle of the data phase, then a clean frame.
        data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
        run_frame(1'b0, 1'b1, -1, 22);
        check("pre_reset_en", 32'(MTxEn), 32'd1);
        #2;
        TxReset    = 1'b1;
        TxStartFrm = 1'b0;
        #1;
        check("reset_async_en", 32'(MTxEn), 32'd0);
        check("reset_async_done", 32'(TxDone), 32'd0);
        check("reset_async_abort", 32'(TxAbort), 32'd0);
        @(negedge MTxClk);
        TxReset = 1'b0;
        @(negedge MTxClk);
        data_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        run_frame(1'b0, 1'b1, -1, -1);
        check("post_reset_done", done_cnt, 32'd1);
        check("post_reset_en_cycles", en_cnt, 32'd34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
